// File: rtl/shift_mix_stage.sv
// AES round stage: ShiftRows then MixColumns (MixColumns bypassed on the final round),
// registered output with a skid buffer. Define SHIFT_MIX_PIPE2_EN for the 2-stage variant.
`timescale 1ns/1ps
module shift_mix_stage #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ROUND_W    = 4,
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ROUND_W-1:0]    in_round,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ROUND_W-1:0]    out_round
);

`ifdef SHIFT_MIX_PIPE2_EN
  localparam int unsigned SK_DEPTH = 2;
`else
  localparam int unsigned SK_DEPTH = 1;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // byte(r + 4c) sits at bits [DATA_WIDTH-1-8(r+4c) -: 8]
  function automatic logic [DATA_WIDTH-1:0] shift_rows(input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] o;
    o = '0;
    for (int unsigned r = 0; r < 4; r++)
      for (int unsigned c = 0; c < 4; c++)
        o[DATA_WIDTH-1-8*(r+4*c) -: 8] = d[DATA_WIDTH-1-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] mix_columns(input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] o;
    logic [7:0]            t [4];
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) t[r] = d[DATA_WIDTH-1-8*(r+4*c) -: 8];
      o[DATA_WIDTH-1-8*(0+4*c) -: 8] = xtime(t[0]) ^ xtime(t[1]) ^ t[1] ^ t[2] ^ t[3];
      o[DATA_WIDTH-1-8*(1+4*c) -: 8] = t[0] ^ xtime(t[1]) ^ xtime(t[2]) ^ t[2] ^ t[3];
      o[DATA_WIDTH-1-8*(2+4*c) -: 8] = t[0] ^ t[1] ^ xtime(t[2]) ^ xtime(t[3]) ^ t[3];
      o[DATA_WIDTH-1-8*(3+4*c) -: 8] = xtime(t[0]) ^ t[0] ^ t[1] ^ t[2] ^ xtime(t[3]);
    end
    return o;
  endfunction

  logic                  accept, consume;
  logic                  new_valid, pending_next;
  logic [DATA_WIDTH-1:0] new_data;
  logic [ROUND_W-1:0]    new_round;

  logic                  or_valid, or_valid_n;
  logic [DATA_WIDTH-1:0] or_data, or_data_n;
  logic [ROUND_W-1:0]    or_round, or_round_n;
  logic [DATA_WIDTH-1:0] sk_data [SK_DEPTH];
  logic [DATA_WIDTH-1:0] sk_data_n [SK_DEPTH];
  logic [ROUND_W-1:0]    sk_round [SK_DEPTH];
  logic [ROUND_W-1:0]    sk_round_n [SK_DEPTH];
  logic [1:0]            sk_count, sk_count_n;
  logic                  ready_q, ready_n;

  assign accept = in_valid & ready_q;
  assign consume = or_valid & out_ready;

`ifdef SHIFT_MIX_PIPE2_EN
  logic                  p_valid, p_bypass;
  logic [DATA_WIDTH-1:0] p_data;
  logic [ROUND_W-1:0]    p_round;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_valid  <= 1'b0;
      p_bypass <= 1'b0;
      p_data   <= '0;
      p_round  <= '0;
    end else begin
      p_valid <= accept;
      if (accept) begin
        p_data   <= shift_rows(in_data);
        p_round  <= in_round;
        p_bypass <= (in_round == ROUND_W'(NUM_ROUNDS));
      end
    end
  end

  always_comb begin
    new_valid    = p_valid;
    new_data     = p_bypass ? p_data : mix_columns(p_data);
    new_round    = p_round;
    pending_next = accept;
  end
`else
  logic [DATA_WIDTH-1:0] sr;

  always_comb begin
    sr           = shift_rows(in_data);
    new_valid    = accept;
    new_data     = (in_round == ROUND_W'(NUM_ROUNDS)) ? sr : mix_columns(sr);
    new_round    = in_round;
    pending_next = 1'b0;
  end
`endif

  // Skid is a shift queue (entry 0 oldest). in_ready is precomputed so that every
  // result already in flight is guaranteed a slot before it arrives.
  always_comb begin
    or_valid_n = or_valid;
    or_data_n  = or_data;
    or_round_n = or_round;
    sk_count_n = sk_count;
    for (int unsigned i = 0; i < SK_DEPTH; i++) begin
      sk_data_n[i]  = sk_data[i];
      sk_round_n[i] = sk_round[i];
    end
    if (consume && sk_count != 2'd0) begin
      or_data_n  = sk_data[0];
      or_round_n = sk_round[0];
      for (int unsigned i = 0; i + 1 < SK_DEPTH; i++) begin
        sk_data_n[i]  = sk_data[i+1];
        sk_round_n[i] = sk_round[i+1];
      end
      for (int unsigned i = 0; i < SK_DEPTH; i++) begin
        if (new_valid && (i + 1 == 32'(sk_count))) begin
          sk_data_n[i]  = new_data;
          sk_round_n[i] = new_round;
        end
      end
      sk_count_n = new_valid ? sk_count : sk_count - 2'd1;
    end else if (consume || !or_valid) begin
      or_valid_n = new_valid;
      if (new_valid) begin
        or_data_n  = new_data;
        or_round_n = new_round;
      end
    end else if (new_valid) begin
      for (int unsigned i = 0; i < SK_DEPTH; i++) begin
        if (i == 32'(sk_count)) begin
          sk_data_n[i]  = new_data;
          sk_round_n[i] = new_round;
        end
      end
      sk_count_n = sk_count + 2'd1;
    end
    ready_n = (32'(sk_count_n) + 32'(pending_next)) < SK_DEPTH;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      or_valid <= 1'b0;
      or_data  <= '0;
      or_round <= '0;
      sk_count <= '0;
      ready_q  <= 1'b1;
      for (int unsigned i = 0; i < SK_DEPTH; i++) begin
        sk_data[i]  <= '0;
        sk_round[i] <= '0;
      end
    end else begin
      or_valid <= or_valid_n;
      or_data  <= or_data_n;
      or_round <= or_round_n;
      sk_count <= sk_count_n;
      ready_q  <= ready_n;
      for (int unsigned i = 0; i < SK_DEPTH; i++) begin
        sk_data[i]  <= sk_data_n[i];
        sk_round[i] <= sk_round_n[i];
      end
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = or_valid;
  assign out_data  = or_data;
  assign out_round = or_round;

endmodule

// File: tb/tb_shift_mix_stage.sv
// Self-checking bench for shift_mix_stage: FIPS-197 vectors, streaming, skid stall,
// async reset and randomized traffic against a GF(2^8) matrix reference model.
`timescale 1ns/1ps
module tb_shift_mix_stage;

`ifdef SHIFT_MIX_PIPE2_EN
  localparam int LAT  = 2;
  localparam int SKID = 2;
`else
  localparam int LAT  = 1;
  localparam int SKID = 1;
`endif
  localparam int NR = 10;

  typedef struct packed {
    logic [127:0] d;
    logic [3:0]   r;
  } item_t;

  logic         clk, rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_data, out_data;
  logic [3:0]   in_round, out_round;

  int    n_checks = 0;
  int    n_fail   = 0;
  item_t exp_q[$];
  logic  hold_prev = 1'b0;
  item_t held;

  shift_mix_stage #(.DATA_WIDTH(128), .ROUND_W(4), .NUM_ROUNDS(NR)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_round(in_round),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_round(out_round)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
    end
    return p;
  endfunction

  // State as a 4x4 byte matrix; output = M * ShiftRows(state) over GF(2^8).
  function automatic logic [127:0] ref_round(input logic [127:0] d, input logic [3:0] rnd);
    logic [7:0]   m  [4][4];
    logic [7:0]   sh [4][4];
    logic [7:0]   base [4];
    logic [7:0]   acc;
    logic [127:0] res = '0;
    base[0] = 8'd2; base[1] = 8'd3; base[2] = 8'd1; base[3] = 8'd1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) m[r][c] = d[127-8*(r+4*c) -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) sh[r][c] = m[r][(c+r)%4];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (rnd == 4'(NR)) acc = sh[r][c];
        else begin
          acc = 8'h00;
          for (int k = 0; k < 4; k++) acc = acc ^ gmul(base[(k-r+4)%4], sh[k][c]);
        end
        res[127-8*(r+4*c) -: 8] = acc;
      end
    return res;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: check output, drive inputs, update model, advance one clock.
  task automatic step(input logic iv, input logic [127:0] id, input logic [3:0] ir,
                      input logic ordy);
    item_t it;
    if (hold_prev) begin
      check("stall_valid", out_valid, 1'b1);
      check("stall_data", out_data, held.d);
      check("stall_round", out_round, held.r);
    end
    in_valid = iv; in_data = id; in_round = ir; out_ready = ordy;
    if (out_valid && ordy) begin
      if (exp_q.size() == 0) check("unexpected_out", out_valid, 1'b0);
      else begin
        it = exp_q.pop_front();
        check("sb_data", out_data, it.d);
        check("sb_round", out_round, it.r);
      end
    end
    if (iv && in_ready) exp_q.push_back('{ref_round(id, ir), ir});
    hold_prev = out_valid && !ordy;
    held = '{out_data, out_round};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int max);
    for (int k = 0; k < max && (exp_q.size() != 0 || out_valid); k++) step(1'b0, '0, '0, 1'b1);
    check("drain_empty", exp_q.size(), 0);
    check("drain_idle", out_valid, 1'b0);
  endtask

  task automatic lat_test(input logic [127:0] v, input logic [3:0] rnd, input logic [127:0] exp);
    int cyc;
    step(1'b1, v, rnd, 1'b1);
    cyc = 1;
    while (!out_valid && cyc < 8) begin
      step(1'b0, '0, '0, 1'b1);
      cyc++;
    end
    check("latency", cyc, LAT);
    check("vec_data", out_data, exp);
    check("vec_round", out_round, rnd);
    drain(10);
  endtask

  task automatic fill_stall();
    for (int k = 0; k < 1 + SKID; k++) begin
      check("fill_ready", in_ready, 1'b1);
      step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 4'($urandom_range(1, 9)), 1'b0);
    end
    check("full_ready", in_ready, 1'b0);
  endtask

  logic [127:0] v_in, v_r1, v_r10;

  initial begin
    v_in  = 128'hd42711aee0bf98f1b8b45de51e415230;
    v_r1  = 128'h046681e5e0cb199a48f8d37a2806264c;
    v_r10 = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    in_valid = 1'b0; in_data = '0; in_round = '0; out_ready = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    check("rst_valid", out_valid, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    check("rst_data", out_data, '0);
    check("rst_round", out_round, '0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    lat_test(v_in, 4'd1, v_r1);
    lat_test(v_in, 4'd10, v_r10);

    // back-to-back stream of 11 states
    for (int i = 0; i < 11 + LAT; i++) begin
      check("stream_valid", out_valid, i >= LAT);
      if (i < 11) check("stream_ready", in_ready, 1'b1);
      step(i < 11, {$urandom, $urandom, $urandom, $urandom}, 4'(i + 1), 1'b1);
    end
    drain(10);

    // stall with skid full, extra input must be ignored
    fill_stall();
    for (int k = 0; k < 3; k++) begin
      check("ignore_ready", in_ready, 1'b0);
      step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 4'd3, 1'b0);
    end
    for (int k = 0; k < 1 + SKID; k++) begin
      check("release_valid", out_valid, 1'b1);
      step(1'b0, '0, '0, 1'b1);
      if (k == 0) check("ready_after_first", in_ready, 1'b1);
    end
    check("release_done", out_valid, 1'b0);
    drain(10);

    // async reset with OR and skid full
    fill_stall();
    #2 rst = 1'b0;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_ready", in_ready, 1'b1);
    check("arst_data", out_data, '0);
    check("arst_round", out_round, '0);
    exp_q.delete();
    hold_prev = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    lat_test(v_in, 4'd1, v_r1);

    // randomized traffic, including rounds 0 and above NUM_ROUNDS
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom, $urandom},
           4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
    drain(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
